// File: rtl/bcd_pkg.sv
// Shared types for the serial BCD modulus checker: digit type, FSM states
// and a BCD range helper.
package bcd_pkg;

    localparam int BCD_W   = 4;
    localparam int BCD_MAX = 9;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    // IDLE: waiting for the first digit of a frame
    // ACCUM: mid-frame, folding digits into the running remainder
    // HOLD: result presented, waiting for the consumer
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } bcd_state_t;

    // True when the nibble is a legal decimal digit.
    function automatic logic is_bcd(input bcd_digit_t d);
        return (d <= bcd_digit_t'(BCD_MAX));
    endfunction

endpackage

// File: rtl/bcd_mod_step.sv
// One Horner step of the decimal-to-modulus fold: r' = (r*10 + d) mod DIVISOR.
// Purely combinational; the intermediate fits in 8 bits (r <= 14, d <= 15).
module bcd_mod_step
    import bcd_pkg::*;
#(
    parameter int DIVISOR = 3,
    parameter int REM_W   = $clog2(DIVISOR)
) (
    input  logic [REM_W-1:0] rem_i,
    input  bcd_digit_t       digit_i,
    output logic [REM_W-1:0] rem_o
);

    logic [7:0] wide;

    // Shift the running remainder one decimal place, add the digit, reduce.
    always_comb begin
        wide  = 8'(rem_i) * 8'd10 + 8'(digit_i);
        rem_o = REM_W'(wide % 8'(DIVISOR));
    end

endmodule

// File: rtl/bcd_mod_stream.sv
// Serial BCD number -> remainder mod DIVISOR, one digit per cycle, MSD first.
// Frames end on in_last; the result is held on a valid/ready output until taken.
// Optional feature: define BCD_CHECK_EN to flag non-BCD digits on out_err.
module bcd_mod_stream
    import bcd_pkg::*;
#(
    parameter int NDIG    = 4,
    parameter int DIVISOR = 3,
    localparam int CNT_W  = $clog2(NDIG + 1),
    localparam int REM_W  = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BCD_W-1:0] in_digit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REM_W-1:0] out_rem,
    output logic             out_div,
    output logic [CNT_W-1:0] out_ndig,
    output logic             out_ovf,
    output logic             out_err
);

    bcd_state_t       state_q, state_d;
    logic [REM_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [REM_W-1:0] out_rem_q, out_rem_d;
    logic             out_div_q, out_div_d;
    logic [CNT_W-1:0] out_ndig_q, out_ndig_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic             first;
    logic             done;
    logic [REM_W-1:0] rem_base, rem_step;
    logic [CNT_W-1:0] cnt_base, cnt_step;
    logic             ovf_base, ovf_step, cnt_sat;

    // Ready drops combinationally while reset is held so nothing slips in.
    assign in_ready  = ~rst & (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid & in_ready;
    assign done      = out_valid & out_ready;
    // A frame always starts from a zero accumulator, whatever is left in acc_q.
    assign first     = (state_q == IDLE);

    assign out_rem   = out_rem_q;
    assign out_div   = out_div_q;
    assign out_ndig  = out_ndig_q;
    assign out_ovf   = out_ovf_q;

    bcd_mod_step #(
        .DIVISOR (DIVISOR),
        .REM_W   (REM_W)
    ) u_step (
        .rem_i   (rem_base),
        .digit_i (bcd_digit_t'(in_digit)),
        .rem_o   (rem_step)
    );

    // Per-digit update of count / overflow; remainder keeps folding past NDIG.
    always_comb begin
        rem_base = first ? '0 : acc_q;
        cnt_base = first ? '0 : cnt_q;
        ovf_base = first ? 1'b0 : ovf_q;
        cnt_sat  = (cnt_base == CNT_W'(NDIG));
        cnt_step = cnt_sat ? cnt_base : cnt_base + 1'b1;
        ovf_step = ovf_base | cnt_sat;
    end

    // Next-state and result capture.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        out_rem_d  = out_rem_q;
        out_div_d  = out_div_q;
        out_ndig_d = out_ndig_q;
        out_ovf_d  = out_ovf_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_d = rem_step;
                    cnt_d = cnt_step;
                    ovf_d = ovf_step;
                    if (in_last) begin
                        state_d    = HOLD;
                        out_rem_d  = rem_step;
                        out_div_d  = (rem_step == '0);
                        out_ndig_d = cnt_step;
                        out_ovf_d  = ovf_step;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            out_rem_q  <= '0;
            out_div_q  <= 1'b0;
            out_ndig_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            out_rem_q  <= out_rem_d;
            out_div_q  <= out_div_d;
            out_ndig_q <= out_ndig_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

`ifdef BCD_CHECK_EN
    logic err_q, err_d;
    logic out_err_q, out_err_d;
    logic err_step;

    // Sticky non-BCD flag; the digit itself still goes through the fold.
    always_comb begin
        err_step  = (first ? 1'b0 : err_q) | ~is_bcd(bcd_digit_t'(in_digit));
        err_d     = err_q;
        out_err_d = out_err_q;
        if (accept) begin
            err_d = err_step;
            if (in_last) out_err_d = err_step;
        end else if (done) begin
            err_d     = 1'b0;
            out_err_d = 1'b0;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            out_err_q <= 1'b0;
        end else begin
            err_q     <= err_d;
            out_err_q <= out_err_d;
        end
    end

    assign out_err = out_err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule
